// File: rtl/opreg_pkg.sv
// ----------------------------------------------------------------------------
// Package: opreg_pkg
// Purpose: Shared constants and helpers for the multi-channel operand register
//          pipeline (operand_reg_pipe / operand_reg_lane).
// Contents:
//   OPREG_MIN_DEPTH  smallest legal pipeline depth
//   ch_slice()       LSB offset of channel c inside a packed multi-channel bus
// The per-stage record (valid + data) depends on DATA_WIDTH, so its typedef
// lives in operand_reg_lane where the width parameter is in scope.
// ----------------------------------------------------------------------------
package opreg_pkg;

    localparam int OPREG_MIN_DEPTH = 1;

    // Channel c occupies bits [ch_slice(c, w) +: w] of a packed bus.
    function automatic int ch_slice(input int c, input int data_width);
        return c * data_width;
    endfunction

endpackage : opreg_pkg

// File: rtl/operand_reg_lane.sv
// ----------------------------------------------------------------------------
// Module: operand_reg_lane
// Purpose: One operand channel: a hold register that captures the operand on
//          load, and a DEPTH-stage valid/data pipeline that re-issues the held
//          operand every advancing cycle.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high; clears everything
//   load       in   capture data into the hold register
//   data       in   operand for this channel
//   stall      in   freeze all pipeline stages (hold register still loads)
//   flush      in   clear all pipeline stages (hold register untouched)
//   data_out   out  last-stage data
//   valid_out  out  last-stage valid
//   held_vld   out  hold register has been loaded since reset
// ----------------------------------------------------------------------------
module operand_reg_lane
    import opreg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  stall,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  held_vld
);

    typedef struct packed {
        logic                  vld;
        logic [DATA_WIDTH-1:0] d;
    } stage_t;

    logic [DATA_WIDTH-1:0] hold_q;
    logic                  held_vld_q;
    stage_t                stage_q [DEPTH];
    stage_t                stage_src;

    // A load bypasses the hold register so the fresh operand enters stage 1
    // on the same edge that captures it.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        stage_src     = '0;
        stage_src.vld = load | held_vld_q;
        stage_src.d   = load ? data : hold_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of its predecessor, giving a true shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q     <= '0;
            held_vld_q <= 1'b0;
            // NOTE: the stage array is reset (not left as plain storage)
            // because its valid bits drive valid_out and data_out must read 0.
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            if (load) begin
                hold_q     <= data;
                held_vld_q <= 1'b1;
            end

            // Flush wins over stall; both leave the hold register alone.
            if (flush) begin
                for (int k = 0; k < DEPTH; k++) begin
                    stage_q[k] <= '0;
                end
            end else if (!stall) begin
                stage_q[0] <= stage_src;
                for (int k = 1; k < DEPTH; k++) begin
                    stage_q[k] <= stage_q[k-1];
                end
            end
        end
    end

    assign data_out  = stage_q[DEPTH-1].d;
    assign valid_out = stage_q[DEPTH-1].vld;
    assign held_vld  = held_vld_q;

endmodule : operand_reg_lane

// File: rtl/operand_reg_pipe.sv
// ----------------------------------------------------------------------------
// Module: operand_reg_pipe
// Purpose: Multi-channel operand register with a parametrised delay pipeline
//          feeding the datapath execute lanes. Each channel holds its last
//          loaded operand and streams it through DEPTH registered stages,
//          with a shared stall and flush.
// Optional feature (macro OPREG_BCAST_EN):
//   adds input bcast; when high, channel 0 of data_in is loaded into every
//   channel and load is forced on all channels.
// Parameters:
//   DATA_WIDTH  operand width in bits
//   NUM_CH      number of channels (>=1)
//   DEPTH       pipeline stages between load and output (>=1)
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   load       in   [NUM_CH]              per-channel load strobe
//   data_in    in   [NUM_CH*DATA_WIDTH]   channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   stall      in   freeze all pipeline stages
//   flush      in   clear all pipeline stages
//   bcast      in   broadcast channel 0 (only with OPREG_BCAST_EN)
//   data_out   out  [NUM_CH*DATA_WIDTH]   last-stage data, same packing
//   valid_out  out  [NUM_CH]              last-stage valid
//   held_vld   out  [NUM_CH]              hold register loaded since reset
// ----------------------------------------------------------------------------
module operand_reg_pipe
    import opreg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 3,
    parameter int DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            load,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         stall,
    input  logic                         flush,
`ifdef OPREG_BCAST_EN
    input  logic                         bcast,
`endif
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]            valid_out,
    output logic [NUM_CH-1:0]            held_vld
);

    generate
        if (DEPTH < OPREG_MIN_DEPTH || NUM_CH < 1) begin : g_param_check
            $fatal(1, "operand_reg_pipe: DEPTH and NUM_CH must both be >= 1");
        end
    endgenerate

    logic [NUM_CH-1:0]            eff_load;
    logic [NUM_CH*DATA_WIDTH-1:0] eff_data;

    // Broadcast mux ahead of the lanes; a plain pass-through when the
    // feature is not built in.
    always_comb begin
        eff_load = load;
        eff_data = data_in;
`ifdef OPREG_BCAST_EN
        if (bcast) begin
            eff_load = '1;
            eff_data = {NUM_CH{data_in[DATA_WIDTH-1:0]}};
        end
`endif
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        operand_reg_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .load      (eff_load[c]),
            .data      (eff_data[ch_slice(c, DATA_WIDTH) +: DATA_WIDTH]),
            .stall     (stall),
            .flush     (flush),
            .data_out  (data_out[ch_slice(c, DATA_WIDTH) +: DATA_WIDTH]),
            .valid_out (valid_out[c]),
            .held_vld  (held_vld[c])
        );
    end

endmodule : operand_reg_pipe
